// File: rtl/pipe_hazard_ctrl.sv
`default_nettype none
//==============================================================================
//  Module   : pipe_hazard_ctrl
//  Purpose  : Hazard and sequencing controller for a 5-stage pipeline.
//             It produces stage-register enables and flushes, the PC source
//             select and the EX-stage forwarding selects. It resolves taken
//             branches seen in EX_MEM, inserts load-use bubbles and freezes
//             the pipeline while a data-memory access is outstanding. A memory
//             access that stays outstanding for too long moves the controller
//             into a terminal error state that only reset leaves.
//  Options  : PERF_CNT_EN - when defined, builds the stall_cycles and
//             flush_events performance counters. When undefined, both
//             ports are tied to zero.
//  Ports    : CLK, RST_N                  clock / async active-low reset
//             id_rs, id_rt                ID-stage source registers
//             ex_rs, ex_rt                EX-stage source registers
//             ex_memread, ex_writereg     EX-stage load flag and destination
//             mem_regwrite, mem_writereg  EX_MEM write-back info
//             wb_regwrite, wb_writereg    MEM_WB write-back info
//             mem_branch, mem_zero        EX_MEM branch resolution
//             mem_access, dmem_ready      data-memory handshake
//             pc_en, ifid_en, exmem_en, memwb_en   stage load enables
//             ifid_flush, idex_flush, exmem_flush  bubble insertion
//             pc_src                      1 selects the branch target
//             fwd_a, fwd_b                ALU operand forwarding selects
//             dmem_req                    data-memory request
//             mem_timeout                 sticky timeout flag
//             stall_cycles, flush_events  performance counters
//  Revision : 1.0 - initial release
//==============================================================================
module pipe_hazard_ctrl #(
    parameter int MAX_WAIT = 16,
    parameter int WAIT_W   = 5,
    parameter int CNT_W    = 32
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic [4:0]       id_rs,
    input  logic [4:0]       id_rt,
    input  logic [4:0]       ex_rs,
    input  logic [4:0]       ex_rt,
    input  logic             ex_memread,
    input  logic [4:0]       ex_writereg,
    input  logic             mem_regwrite,
    input  logic [4:0]       mem_writereg,
    input  logic             wb_regwrite,
    input  logic [4:0]       wb_writereg,
    input  logic             mem_branch,
    input  logic             mem_zero,
    input  logic             mem_access,
    input  logic             dmem_ready,
    output logic             pc_en,
    output logic             ifid_en,
    output logic             exmem_en,
    output logic             memwb_en,
    output logic             ifid_flush,
    output logic             idex_flush,
    output logic             exmem_flush,
    output logic             pc_src,
    output logic [1:0]       fwd_a,
    output logic [1:0]       fwd_b,
    output logic             dmem_req,
    output logic             mem_timeout,
    output logic [CNT_W-1:0] stall_cycles,
    output logic [CNT_W-1:0] flush_events
);

    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MAX_WAIT - 1);

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_MEM_WAIT = 2'd1,
        ST_ERR      = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [WAIT_W-1:0]   wait_cnt_q, wait_cnt_d;
    logic                mem_timeout_q, mem_timeout_d;

    logic                w_frozen;
    logic                w_branch;
    logic                w_lu_hit;
    logic                w_load_use;

    //--------------------------------------------------------------------------
    // Hazard conditions. Priority is freeze > branch > load-use, so each
    // lower-priority condition is masked by the ones above it.
    //--------------------------------------------------------------------------
    always_comb begin
        w_frozen   = (state_q == ST_ERR)
                   || ((state_q == ST_MEM_WAIT) && !dmem_ready)
                   || ((state_q == ST_RUN) && mem_access && !dmem_ready);
        w_branch   = !w_frozen && mem_branch && mem_zero;
        w_lu_hit   = ex_memread && (ex_writereg != 5'd0)
                   && ((ex_writereg == id_rs) || (ex_writereg == id_rt));
        w_load_use = !w_frozen && !w_branch && w_lu_hit;
    end

    //--------------------------------------------------------------------------
    // Sequencer: next state, wait counter and sticky timeout flag.
    //--------------------------------------------------------------------------
    always_comb begin
        state_d       = state_q;
        wait_cnt_d    = wait_cnt_q;
        mem_timeout_d = mem_timeout_q;
        case (state_q)
            ST_RUN: begin
                wait_cnt_d = '0;
                if (mem_access && !dmem_ready) begin
                    state_d = ST_MEM_WAIT;
                end
            end
            ST_MEM_WAIT: begin
                if (dmem_ready) begin
                    state_d = ST_RUN;
                end else begin
                    wait_cnt_d = wait_cnt_q + 1'b1;
                    if (wait_cnt_q == WAIT_LAST) begin
                        state_d       = ST_ERR;
                        mem_timeout_d = 1'b1;
                    end
                end
            end
            ST_ERR: begin
                state_d = ST_ERR;
            end
            default: begin
                state_d    = ST_RUN;
                wait_cnt_d = '0;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q       <= ST_RUN;
            wait_cnt_q    <= '0;
            mem_timeout_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            wait_cnt_q    <= wait_cnt_d;
            mem_timeout_q <= mem_timeout_d;
        end
    end

    assign mem_timeout = mem_timeout_q;

    //--------------------------------------------------------------------------
    // Pipeline controls. Reset values are applied directly from RST_N so the
    // stage registers see bubbles for the whole time reset is asserted.
    //--------------------------------------------------------------------------
    always_comb begin
        pc_en       = 1'b1;
        ifid_en     = 1'b1;
        exmem_en    = 1'b1;
        memwb_en    = 1'b1;
        ifid_flush  = 1'b0;
        idex_flush  = 1'b0;
        exmem_flush = 1'b0;
        pc_src      = 1'b0;
        dmem_req    = mem_access && (state_q != ST_ERR);
        if (!RST_N) begin
            pc_en       = 1'b0;
            ifid_en     = 1'b0;
            exmem_en    = 1'b0;
            memwb_en    = 1'b0;
            ifid_flush  = 1'b1;
            idex_flush  = 1'b1;
            exmem_flush = 1'b1;
            dmem_req    = 1'b0;
        end else if (w_frozen) begin
            pc_en    = 1'b0;
            ifid_en  = 1'b0;
            exmem_en = 1'b0;
            memwb_en = 1'b0;
        end else if (w_branch) begin
            // Three younger instructions are on the wrong path.
            pc_src      = 1'b1;
            ifid_flush  = 1'b1;
            idex_flush  = 1'b1;
            exmem_flush = 1'b1;
        end else if (w_load_use) begin
            // Hold PC and IF_ID, drop a bubble into ID_EX; older stages drain.
            pc_en      = 1'b0;
            ifid_en    = 1'b0;
            idex_flush = 1'b1;
        end
    end

    //--------------------------------------------------------------------------
    // Forwarding selects: the younger EX_MEM result wins over MEM_WB.
    //--------------------------------------------------------------------------
    always_comb begin
        fwd_a = 2'b00;
        fwd_b = 2'b00;
        if (RST_N) begin
            if (mem_regwrite && (mem_writereg != 5'd0) && (mem_writereg == ex_rs)) begin
                fwd_a = 2'b10;
            end else if (wb_regwrite && (wb_writereg != 5'd0) && (wb_writereg == ex_rs)) begin
                fwd_a = 2'b01;
            end
            if (mem_regwrite && (mem_writereg != 5'd0) && (mem_writereg == ex_rt)) begin
                fwd_b = 2'b10;
            end else if (wb_regwrite && (wb_writereg != 5'd0) && (wb_writereg == ex_rt)) begin
                fwd_b = 2'b01;
            end
        end
    end

    //--------------------------------------------------------------------------
    // Optional performance counters.
    //--------------------------------------------------------------------------
`ifdef PERF_CNT_EN
    logic [CNT_W-1:0] stall_cycles_q, stall_cycles_d;
    logic [CNT_W-1:0] flush_events_q, flush_events_d;

    always_comb begin
        stall_cycles_d = stall_cycles_q + CNT_W'(w_frozen || w_load_use);
        flush_events_d = flush_events_q + CNT_W'(w_branch);
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            stall_cycles_q <= '0;
            flush_events_q <= '0;
        end else begin
            stall_cycles_q <= stall_cycles_d;
            flush_events_q <= flush_events_d;
        end
    end

    assign stall_cycles = stall_cycles_q;
    assign flush_events = flush_events_q;
`else
    assign stall_cycles = '0;
    assign flush_events = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_pipe_hazard_ctrl.sv
`default_nettype none
//==============================================================================
//  Module   : tb_pipe_hazard_ctrl
//  Purpose  : Self-checking bench for pipe_hazard_ctrl. Directed steps follow
//             the block's intended scenarios, followed by a randomized run.
//             Expected values come from a behavioural model that tracks the
//             memory-wait mode and a count of consecutive unanswered cycles.
//  Revision : 1.0 - initial release
//==============================================================================
module tb_pipe_hazard_ctrl;

    localparam int MAX_WAIT = 16;

    logic        CLK = 1'b0;
    logic        RST_N;
    logic [4:0]  id_rs, id_rt, ex_rs, ex_rt, ex_writereg, mem_writereg, wb_writereg;
    logic        ex_memread, mem_regwrite, wb_regwrite, mem_branch, mem_zero;
    logic        mem_access, dmem_ready;
    logic        pc_en, ifid_en, exmem_en, memwb_en;
    logic        ifid_flush, idex_flush, exmem_flush, pc_src, dmem_req, mem_timeout;
    logic [1:0]  fwd_a, fwd_b;
    logic [31:0] stall_cycles, flush_events;

    int checks = 0;
    int errors = 0;

    // Model state: 0 = running, 1 = waiting for memory, 2 = timed out.
    int          m_mode;
    int          m_missed;
    logic        m_to;
    logic [31:0] m_stall, m_flush;

    pipe_hazard_ctrl #(.MAX_WAIT(MAX_WAIT), .WAIT_W(5), .CNT_W(32)) dut (
        .CLK(CLK), .RST_N(RST_N),
        .id_rs(id_rs), .id_rt(id_rt), .ex_rs(ex_rs), .ex_rt(ex_rt),
        .ex_memread(ex_memread), .ex_writereg(ex_writereg),
        .mem_regwrite(mem_regwrite), .mem_writereg(mem_writereg),
        .wb_regwrite(wb_regwrite), .wb_writereg(wb_writereg),
        .mem_branch(mem_branch), .mem_zero(mem_zero),
        .mem_access(mem_access), .dmem_ready(dmem_ready),
        .pc_en(pc_en), .ifid_en(ifid_en), .exmem_en(exmem_en), .memwb_en(memwb_en),
        .ifid_flush(ifid_flush), .idex_flush(idex_flush), .exmem_flush(exmem_flush),
        .pc_src(pc_src), .fwd_a(fwd_a), .fwd_b(fwd_b), .dmem_req(dmem_req),
        .mem_timeout(mem_timeout), .stall_cycles(stall_cycles), .flush_events(flush_events)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_idle();
        {id_rs, id_rt, ex_rs, ex_rt, ex_writereg, mem_writereg, wb_writereg} = '0;
        {ex_memread, mem_regwrite, wb_regwrite, mem_branch, mem_zero} = '0;
        mem_access = 1'b0;
        dmem_ready = 1'b1;
    endtask

    task automatic set_random(input int access_pct, input int ready_pct);
        id_rs = 5'($urandom_range(0, 7)); id_rt = 5'($urandom_range(0, 7));
        ex_rs = 5'($urandom_range(0, 7)); ex_rt = 5'($urandom_range(0, 7));
        ex_writereg  = 5'($urandom_range(0, 7));
        mem_writereg = 5'($urandom_range(0, 7));
        wb_writereg  = 5'($urandom_range(0, 7));
        ex_memread   = 1'($urandom_range(0, 1));
        mem_regwrite = 1'($urandom_range(0, 1));
        wb_regwrite  = 1'($urandom_range(0, 1));
        mem_branch   = 1'($urandom_range(0, 1));
        mem_zero     = 1'($urandom_range(0, 1));
        mem_access   = ($urandom_range(0, 99) < access_pct);
        dmem_ready   = ($urandom_range(0, 99) < ready_pct);
    endtask

    task automatic model_reset();
        m_mode = 0; m_missed = 0; m_to = 1'b0; m_stall = '0; m_flush = '0;
    endtask

    function automatic logic [1:0] ref_fwd(input logic [4:0] src);
        if (mem_regwrite && mem_writereg != 0 && mem_writereg == src) return 2'b10;
        if (wb_regwrite && wb_writereg != 0 && wb_writereg == src) return 2'b01;
        return 2'b00;
    endfunction

    // One clock cycle in reset: checks reset values with the current inputs.
    task automatic rst_cycle();
        @(negedge CLK);
        chk("rst_enables", {pc_en, ifid_en, exmem_en, memwb_en}, 4'b0000);
        chk("rst_flushes", {ifid_flush, idex_flush, exmem_flush}, 3'b111);
        chk("rst_pc_src", pc_src, 1'b0);
        chk("rst_fwd", {fwd_a, fwd_b}, 4'b0000);
        chk("rst_dmem_req", dmem_req, 1'b0);
        chk("rst_timeout", mem_timeout, 1'b0);
        chk("rst_stall_cnt", stall_cycles, 32'd0);
        chk("rst_flush_cnt", flush_events, 32'd0);
        @(posedge CLK);
        #1;
    endtask

    // One operating cycle: compare every output against the model, then
    // advance the model at the clock edge.
    task automatic run_cycle(input string tag);
        logic frozen, branch, lu;
        @(negedge CLK);
        frozen = (m_mode == 2) || (!dmem_ready && (m_mode == 1 || mem_access));
        branch = !frozen && mem_branch && mem_zero;
        lu     = !frozen && !branch && ex_memread && ex_writereg != 0
                 && (ex_writereg == id_rs || ex_writereg == id_rt);
        chk({tag, "_pc_en"},    pc_en,    !frozen && !lu);
        chk({tag, "_ifid_en"},  ifid_en,  !frozen && !lu);
        chk({tag, "_exmem_en"}, exmem_en, !frozen);
        chk({tag, "_memwb_en"}, memwb_en, !frozen);
        chk({tag, "_flushes"},  {ifid_flush, idex_flush, exmem_flush},
            {branch, branch || lu, branch});
        chk({tag, "_pc_src"},   pc_src,   branch);
        chk({tag, "_fwd_a"},    fwd_a,    ref_fwd(ex_rs));
        chk({tag, "_fwd_b"},    fwd_b,    ref_fwd(ex_rt));
        chk({tag, "_dmem_req"}, dmem_req, mem_access && m_mode != 2);
        chk({tag, "_timeout"},  mem_timeout, m_to);
`ifdef PERF_CNT_EN
        chk({tag, "_stall_cnt"}, stall_cycles, m_stall);
        chk({tag, "_flush_cnt"}, flush_events, m_flush);
`else
        chk({tag, "_stall_cnt"}, stall_cycles, 32'd0);
        chk({tag, "_flush_cnt"}, flush_events, 32'd0);
`endif
        @(posedge CLK);
        if (frozen || lu) m_stall = m_stall + 1;
        if (branch)       m_flush = m_flush + 1;
        if (m_mode == 0) begin
            if (mem_access && !dmem_ready) begin m_mode = 1; m_missed = 0; end
        end else if (m_mode == 1) begin
            if (dmem_ready) m_mode = 0;
            else begin
                m_missed = m_missed + 1;
                if (m_missed == MAX_WAIT) begin m_mode = 2; m_to = 1'b1; end
            end
        end
        #1;
    endtask

    initial begin
        // Reset held for three cycles with inputs toggling.
        RST_N = 1'b0;
        model_reset();
        for (int i = 0; i < 3; i++) begin
            set_random(50, 50);
            rst_cycle();
        end
        set_idle();
        RST_N = 1'b1;
        run_cycle("idle");
        run_cycle("idle2");

        // Load-use hit for one cycle, then gone.
        ex_memread = 1'b1; ex_writereg = 5'd8; id_rs = 5'd8;
        run_cycle("lu_hit");
        set_idle();
        run_cycle("lu_after");
        ex_memread = 1'b1; ex_writereg = 5'd0; id_rs = 5'd0;
        run_cycle("lu_r0");
        set_idle();
        ex_memread = 1'b1; ex_writereg = 5'd3; id_rt = 5'd3;
        run_cycle("lu_rt");
        set_idle();

        // Forwarding priority.
        mem_regwrite = 1'b1; wb_regwrite = 1'b1;
        mem_writereg = 5'd5; wb_writereg = 5'd5; ex_rs = 5'd5;
        run_cycle("fwd_mem");
        mem_regwrite = 1'b0;
        run_cycle("fwd_wb");
        ex_rt = 5'd5; mem_regwrite = 1'b1;
        run_cycle("fwd_b_mem");
        mem_regwrite = 1'b0;
        run_cycle("fwd_b_wb");
        set_idle();

        // Memory wait: four unanswered cycles, then completion.
        mem_access = 1'b1; dmem_ready = 1'b0;
        for (int i = 0; i < 4; i++) run_cycle("mwait");
        dmem_ready = 1'b1;
        run_cycle("mwait_done");
        set_idle();
        run_cycle("mwait_idle");

        // Branch together with a load-use hazard.
        mem_branch = 1'b1; mem_zero = 1'b1;
        ex_memread = 1'b1; ex_writereg = 5'd4; id_rs = 5'd4;
        run_cycle("br_lu");
        set_idle();

        // Branch while frozen is held off until memory answers.
        mem_access = 1'b1; dmem_ready = 1'b0; mem_branch = 1'b1; mem_zero = 1'b1;
        run_cycle("br_frz0");
        run_cycle("br_frz1");
        dmem_ready = 1'b1;
        run_cycle("br_release");
        set_idle();
        run_cycle("br_idle");

        // Randomized operation.
        for (int i = 0; i < 400; i++) begin
            set_random(40, 70);
            run_cycle("rand");
        end

        // Timeout: memory never answers.
        set_idle();
        run_cycle("pre_to");
        mem_access = 1'b1; dmem_ready = 1'b0;
        for (int i = 0; i < MAX_WAIT + 4; i++) run_cycle("to_wait");
        chk("to_model_err", mem_timeout, 1'b1);
        for (int i = 0; i < 6; i++) begin
            set_random(60, 50);
            run_cycle("to_err");
        end

        // Asynchronous reset clears the error between clock edges.
        RST_N = 1'b0;
        #1;
        chk("async_timeout", mem_timeout, 1'b0);
        chk("async_pc_en", pc_en, 1'b0);
        chk("async_flush", idex_flush, 1'b1);
        model_reset();
        rst_cycle();
        set_idle();
        RST_N = 1'b1;
        run_cycle("post_rst");
        for (int i = 0; i < 100; i++) begin
            set_random(30, 80);
            run_cycle("rand2");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
